mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for the single-port main memory shared by the instruction-fetch path and the load/store data path of the multicycle RISC-V core. It accepts level requests from two requesters (fetch, data), grants one access at a time, drives the memory port for exactly one issue cycle, and waits a fixed read latency. It returns read data with a one-cycle acknowledge pulse, so the control FSM advances on `ack` instead of assuming fixed memory timing.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width
- `MEM_LAT`, 2, cycles from the address-issue cycle to `mem_rdata` valid; legal range 1..15

- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch read request (level)
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  DATA_W  fetch read data (registered)
- `d_req`  in  1  data request (level)
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle pulse; load data valid or store done
- `d_rdata`  out  DATA_W  load data (registered)
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_we`  out  1  memory write strobe
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state != IDLE
- `owner`  out  1  current grant: 0 = fetch, 1 = data; meaningful only while `busy`

## Operation
- States: IDLE, ACCESS, WAIT, RESP. The latency counter is 4 bits.
- IDLE: sample `if_req`/`d_req`.
  - One request pending: grant it.
  - Both pending: grant the requester not granted last (`last_owner`). `last_owner` resets to fetch, so the first tie goes to data.
  - On grant: latch addr, we (forced 0 for fetch), wdata and owner into hold registers; update `last_owner`; go to ACCESS.
- ACCESS (exactly one cycle):
  - `mem_addr`/`mem_wdata` come from the hold registers. `mem_we` = latched we, high only in this state.
  - Store: go to RESP.
  - Load/fetch: load counter = MEM_LAT and go to WAIT.
- WAIT: decrement the counter each cycle.
  - In the cycle the counter is 1, capture `mem_rdata` into `if_rdata` or `d_rdata` (by owner) and go to RESP.
  - The other requester's rdata register is unchanged.
- RESP: assert the owner's ack for one cycle; go to IDLE.
- Requests are sampled only in IDLE; `req` changes in other states are ignored.
- A requester holds `req` and its inputs stable until its ack cycle. A `req` still high in the cycle after ack is treated as a new request.
- `mem_addr`/`mem_wdata` hold their last latched value outside ACCESS; the memory must qualify on `mem_we` only.
- Reset values: state IDLE, `if_ack` = `d_ack` = `mem_we` = 0, `busy` = 0, `owner` = 0, `last_owner` = fetch, hold registers 0, `if_rdata` = `d_rdata` = 0, counter 0.
- Reset mid-operation aborts the transfer: no ack is issued, and `mem_we` drops immediately (asynchronous).

## Timing
- Request high in IDLE cycle T0 → ACCESS in cycle A = T0+1.
- Store: `mem_we` = 1 in A only; `d_ack` in A+1; IDLE in A+2.
- Load/fetch: WAIT in A+1..A+MEM_LAT; `mem_rdata` sampled at the end of A+MEM_LAT; ack and rdata valid in A+MEM_LAT+1; IDLE in A+MEM_LAT+2.
- Throughput: one store per 3 cycles; one read per MEM_LAT+3 cycles.
- Starvation bound: with both requesters continuously active, each is granted at least every second arbitration.
- No combinational path from any input to any output except `mem_we`/`mem_addr`/`mem_wdata` through state registers; all outputs are registered or state-decoded.

## Test plan
- Fetch read, MEM_LAT=2: `if_req`=1, `if_addr`=0x40 in cycle 0; memory returns 0xDEADBEEF in cycle 3 → `mem_addr`=0x40 in cycle 1, `if_ack`=1 with `if_rdata`=0xDEADBEEF in cycle 4 only, `d_ack` stays 0.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0x55 in cycle 0 → `mem_we`=1 with `mem_addr`=0x100 and `mem_wdata`=0x55 in cycle 1 only; `d_ack` in cycle 2; `d_rdata` unchanged.
- Tie after reset: both requests high from cycle 0 and held until their acks → data is served first (`owner`=1); fetch ACCESS starts 2 cycles after `d_ack`. If both are re-raised, data wins the next tie.
- Starvation: `d_req` held high continuously with loads, `if_req` raised once → fetch is granted at the arbitration immediately following the current data transfer.
- Reset during WAIT: assert `reset` while `busy`=1 in WAIT → `busy`=0, no ack, `mem_we`=0 immediately; the next fetch completes with normal timing.
- MEM_LAT=1 build: load issued in cycle A → `d_ack` in A+2 with the data sampled at the end of A+1.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes and memory-side bus of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy, owner
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: alternating-priority arbiter sequencing fetch and load/store accesses onto one memory port.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    state_t            state;
    logic [3:0]        cnt;
    logic              last_owner;
    logic              owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt_d;
    // On a tie, the requester that was not served last wins.
    assign gnt_d = bus.d_req & (~bus.if_req | ~last_owner);
    assign bus.busy = state != IDLE;
    assign bus.owner = owner;
    assign bus.mem_addr = addr;
    assign bus.mem_wdata = wdata;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            last_owner   <= 1'b0;
            owner        <= 1'b0;
            we           <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
            bus.if_ack   <= 1'b0;
            bus.d_ack    <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.mem_we <= 1'b0;
            unique case (state)
                IDLE: if (bus.if_req | bus.d_req) begin
                    owner      <= gnt_d;
                    last_owner <= gnt_d;
                    addr       <= gnt_d ? bus.d_addr : bus.if_addr;
                    wdata      <= bus.d_wdata;
                    we         <= gnt_d & bus.d_we;
                    bus.mem_we <= gnt_d & bus.d_we;
                    state      <= ACCESS;
                end
                ACCESS: if (we) begin
                    bus.d_ack <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt   <= 4'(MEM_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (owner) bus.d_rdata <= bus.mem_rdata;
                        else bus.if_rdata <= bus.mem_rdata;
                        bus.if_ack <= ~owner;
                        bus.d_ack  <= owner;
                        state      <= RESP;
                    end
                end
                RESP: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tests of the memory port arbiter at MEM_LAT=2 and MEM_LAT=1.
module tb_mem_port_arbiter;
    localparam logic [63:0] K = 64'hF0F0_0000_0000_F0F0;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n = 0;
    int fails = 0;
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus1 ();
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, owner (only while busy), if_ack, d_ack, mem_we}
    function automatic logic [4:0] st();
        return {bus.busy, bus.busy & bus.owner, bus.if_ack, bus.d_ack, bus.mem_we};
    endfunction

    function automatic logic [4:0] st1();
        return {bus1.busy, bus1.busy & bus1.owner, bus1.if_ack, bus1.d_ack, bus1.mem_we};
    endfunction

    task automatic drain(input string name);
        int k = 0;
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        while (bus.busy && k < 12) begin
            bus.mem_rdata = bus.mem_addr ^ K;
            tick();
            k++;
        end
        n++;
        if (bus.busy !== 1'b0) begin $display("FAIL %s_drain busy still high after %0d cycles", name, k); fails++; end
    endtask

    task automatic test_reset();
        tick();
        n++;
        if (st() !== 5'b00000) begin $display("FAIL reset_status got %b exp 00000", st()); fails++; end
        n++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
            $display("FAIL reset_regs got addr=%h wdata=%h if_rdata=%h d_rdata=%h exp all 0", bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata); fails++;
        end
        n++;
        if (st1() !== 5'b00000) begin $display("FAIL reset_status_lat1 got %b exp 00000", st1()); fails++; end
        reset = 1'b0;
    endtask

    task automatic test_fetch(input logic [63:0] a, input logic [63:0] d, input string name);
        logic [4:0] e [6];
        e = '{5'b00000, 5'b10000, 5'b10000, 5'b10000, 5'b10100, 5'b00000};
        for (int c = 0; c < 6; c++) begin
            bus.if_req = c < 4;
            bus.if_addr = a;
            bus.mem_rdata = c == 3 ? d : 64'h1111;
            n++;
            if (st() !== e[c]) begin $display("FAIL %s_status cycle %0d got %b exp %b", name, c, st(), e[c]); fails++; end
            if (c == 1) begin
                n++;
                if (bus.mem_addr !== a) begin $display("FAIL %s_addr got %h exp %h", name, bus.mem_addr, a); fails++; end
            end
            if (c >= 4) begin
                n++;
                if (bus.if_rdata !== d) begin $display("FAIL %s_rdata cycle %0d got %h exp %h", name, c, bus.if_rdata, d); fails++; end
            end
            if (c == 5) begin
                n++;
                if (bus.d_rdata !== 64'h0) begin $display("FAIL %s_d_rdata got %h exp 0", name, bus.d_rdata); fails++; end
            end
            tick();
        end
    endtask

    task automatic test_store();
        logic [4:0] e [4];
        e = '{5'b00000, 5'b11001, 5'b11010, 5'b00000};
        for (int c = 0; c < 4; c++) begin
            bus.d_req = c < 2;
            bus.d_we = 1'b1;
            bus.d_addr = 64'h100;
            bus.d_wdata = 64'h55;
            n++;
            if (st() !== e[c]) begin $display("FAIL store_status cycle %0d got %b exp %b", c, st(), e[c]); fails++; end
            if (c == 1) begin
                n++;
                if (bus.mem_addr !== 64'h100 || bus.mem_wdata !== 64'h55) begin
                    $display("FAIL store_bus got addr=%h wdata=%h exp 100/55", bus.mem_addr, bus.mem_wdata); fails++;
                end
            end
            if (c == 3) begin
                n++;
                if (bus.d_rdata !== 64'h0) begin $display("FAIL store_d_rdata got %h exp 0", bus.d_rdata); fails++; end
            end
            tick();
        end
        bus.d_we = 1'b0;
    endtask

    task automatic test_tie();
        logic [4:0] e [12];
        e = '{5'b00000, 5'b11000, 5'b11000, 5'b11000, 5'b11010, 5'b00000,
              5'b10000, 5'b10000, 5'b10000, 5'b10100, 5'b00000, 5'b11000};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.d_req = c < 4 || c >= 10;
            bus.d_we = 1'b0;
            bus.d_addr = 64'h200;
            bus.if_req = c < 9 || c >= 10;
            bus.if_addr = 64'h300;
            bus.mem_rdata = bus.mem_addr ^ K;
            n++;
            if (st() !== e[c]) begin $display("FAIL tie_status cycle %0d got %b exp %b", c, st(), e[c]); fails++; end
            if (c == 4) begin
                n++;
                if (bus.d_rdata !== (64'h200 ^ K)) begin $display("FAIL tie_d_rdata got %h exp %h", bus.d_rdata, 64'h200 ^ K); fails++; end
            end
            if (c == 9) begin
                n++;
                if (bus.if_rdata !== (64'h300 ^ K)) begin $display("FAIL tie_if_rdata got %h exp %h", bus.if_rdata, 64'h300 ^ K); fails++; end
            end
            tick();
        end
        drain("tie");
    endtask

    task automatic test_starvation();
        logic [4:0] e [12];
        e = '{5'b00000, 5'b11000, 5'b11000, 5'b11000, 5'b11010, 5'b00000,
              5'b10000, 5'b10000, 5'b10000, 5'b10100, 5'b00000, 5'b11000};
        for (int c = 0; c < 12; c++) begin
            bus.d_req = 1'b1;
            bus.d_addr = 64'h600;
            bus.if_req = c >= 2 && c < 9;
            bus.if_addr = 64'h700;
            bus.mem_rdata = bus.mem_addr ^ K;
            n++;
            if (st() !== e[c]) begin $display("FAIL starve_status cycle %0d got %b exp %b", c, st(), e[c]); fails++; end
            if (c == 6) begin
                n++;
                if (bus.mem_addr !== 64'h700) begin $display("FAIL starve_addr got %h exp 700", bus.mem_addr); fails++; end
            end
            if (c == 9) begin
                n++;
                if (bus.if_rdata !== (64'h700 ^ K)) begin $display("FAIL starve_if_rdata got %h exp %h", bus.if_rdata, 64'h700 ^ K); fails++; end
            end
            tick();
        end
        drain("starve");
    endtask

    task automatic test_reset_wait();
        bus.if_req = 1'b1;
        bus.if_addr = 64'h80;
        bus.mem_rdata = 64'h5;
        tick();
        tick();
        n++;
        if (st() !== 5'b10000) begin $display("FAIL rstwait_pre got %b exp 10000", st()); fails++; end
        reset = 1'b1;
        #1;
        n++;
        if (st() !== 5'b00000) begin $display("FAIL rstwait_async got %b exp 00000", st()); fails++; end
        n++;
        if (bus.if_rdata !== 64'h0) begin $display("FAIL rstwait_if_rdata got %h exp 0", bus.if_rdata); fails++; end
        bus.if_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n++;
            if (st() !== 5'b00000) begin $display("FAIL rstwait_noack cycle %0d got %b exp 00000", c, st()); fails++; end
            tick();
        end
        test_fetch(64'h88, 64'h1234, "rstwait_fetch");
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 64'h900;
        tick();
        n++;
        if (st() !== 5'b11001) begin $display("FAIL rststore_pre got %b exp 11001", st()); fails++; end
        reset = 1'b1;
        #1;
        n++;
        if (st() !== 5'b00000) begin $display("FAIL rststore_async got %b exp 00000", st()); fails++; end
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n++;
        if (st() !== 5'b00000) begin $display("FAIL rststore_noack got %b exp 00000", st()); fails++; end
    endtask

    task automatic test_lat1();
        logic [4:0] e [5];
        e = '{5'b00000, 5'b11000, 5'b11000, 5'b11010, 5'b00000};
        for (int c = 0; c < 5; c++) begin
            bus1.d_req = c < 3;
            bus1.d_we = 1'b0;
            bus1.d_addr = 64'h500;
            bus1.mem_rdata = c == 2 ? 64'h77 : 64'h99;
            n++;
            if (st1() !== e[c]) begin $display("FAIL lat1_status cycle %0d got %b exp %b", c, st1(), e[c]); fails++; end
            if (c == 3) begin
                n++;
                if (bus1.d_rdata !== 64'h77) begin $display("FAIL lat1_d_rdata got %h exp 77", bus1.d_rdata); fails++; end
            end
            tick();
        end
    endtask

    initial begin
        {bus.if_req, bus.d_req, bus.d_we} = '0;
        {bus.if_addr, bus.d_addr, bus.d_wdata, bus.mem_rdata} = '0;
        {bus1.if_req, bus1.d_req, bus1.d_we} = '0;
        {bus1.if_addr, bus1.d_addr, bus1.d_wdata, bus1.mem_rdata} = '0;
        test_reset();
        test_fetch(64'h40, 64'hDEADBEEF, "fetch");
        test_store();
        test_tie();
        test_starvation();
        test_reset_wait();
        test_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d assertions", n);
        $fatal(1, "timeout");
    end
endmodule
